// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_n slice.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Channel-index width; never narrower than one bit.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search: first requester at or after ptr, with wrap-around.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt_idx = '0;
        gnt_vld = 1'b0;
        // Walk from the farthest offset back to ptr so the nearest requester is written last.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_CH]) begin
                gnt_idx = SEL_W'((int'(ptr) + i) % NUM_CH);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered valid/ready stream multiplexer, external select or round-robin.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic              out_last_q,  out_last_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;
`ifdef STREAM_MUX_LOCK_EN
    logic              lock_q,      lock_d;
    logic [SEL_W-1:0]  lock_ch_q,   lock_ch_d;
    logic              lock_vld;
`endif

    logic [SEL_W-1:0]  rr_idx;
    logic              rr_vld;
    logic              sel_vld;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [DATA_W-1:0] gnt_data;
    logic              gnt_last;
    logic              load;
    logic              xfer;
    logic              ptr_adv;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    assign load = !out_valid_q || out_ready;
    assign xfer = load && gnt_vld && !rst;

    // Grant selection; an out-of-range sel matches no channel and so grants nothing.
    always_comb begin
        sel_vld = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (SEL_W'(c) == sel) sel_vld = in_valid[c];
        end
        gnt_idx = sel;
        gnt_vld = sel_vld;
        if (mode == MODE_RR) begin
            gnt_idx = rr_idx;
            gnt_vld = rr_vld;
        end
`ifdef STREAM_MUX_LOCK_EN
        lock_vld = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (SEL_W'(c) == lock_ch_q) lock_vld = in_valid[c];
        end
        if (lock_q) begin
            gnt_idx = lock_ch_q;
            gnt_vld = lock_vld;
        end
`endif
    end

    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        in_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (SEL_W'(c) == gnt_idx) begin
                gnt_data    = in_data[c*DATA_W +: DATA_W];
                gnt_last    = in_last[c];
                in_ready[c] = xfer;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        ptr_d       = ptr_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            out_last_d  = gnt_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        ptr_adv = xfer && (mode == MODE_RR);
`ifdef STREAM_MUX_LOCK_EN
        ptr_adv = ptr_adv && gnt_last;
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            lock_d    = !gnt_last;
            lock_ch_d = gnt_idx;
        end
`endif
        if (ptr_adv) begin
            ptr_d = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the output register is reset so a reset mid-stall leaves no stale beat visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            ptr_q       <= '0;
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: per-cycle vector table plus packet, stall-reset and narrow-select sequences.
module tb_stream_mux_n;
    import stream_mux_pkg::*;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_last3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_last3;
    logic        out_valid3;
    logic        out_ready3;

    int n_vec = 0;
    int n_err = 0;

    stream_mux_n #(.NUM_CH(4), .DATA_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_n #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_last   (in_last3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_last  (out_last3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t vecs[16];

    logic [1:0] exp_ch_a   [5];
    logic       exp_last_a [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ch_data(input logic [1:0] c);
        case (c)
            2'd0: return 8'hC0;
            2'd1: return 8'hB1;
            2'd2: return 8'hA5;
            default: return 8'hD3;
        endcase
    endfunction

    initial begin
        // mode, sel, in_valid, out_ready, exp in_ready, exp out_valid, exp out_ch
        vecs[0]  = '{MODE_SEL, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[1]  = '{MODE_SEL, 2'd3, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[2]  = '{MODE_SEL, 2'd3, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[3]  = '{MODE_RR,  2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[4]  = '{MODE_RR,  2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[5]  = '{MODE_RR,  2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[6]  = '{MODE_RR,  2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[7]  = '{MODE_RR,  2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[8]  = '{MODE_RR,  2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[9]  = '{MODE_RR,  2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[10] = '{MODE_RR,  2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[11] = '{MODE_RR,  2'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[12] = '{MODE_SEL, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[13] = '{MODE_RR,  2'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[14] = '{MODE_RR,  2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[15] = '{MODE_RR,  2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

`ifdef STREAM_MUX_LOCK_EN
        exp_ch_a   = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        exp_last_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        exp_ch_a   = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        exp_last_a = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

        rst       = 1'b1;
        mode      = MODE_RR;
        sel       = 2'd0;
        in_data   = 32'hD3A5B1C0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        mode3      = MODE_SEL;
        sel3       = 2'd0;
        in_data3   = 24'h332211;
        in_valid3  = 3'b000;
        in_last3   = 3'b111;
        out_ready3 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data",  32'(out_data),  32'd0);
        check("reset out_ch",    32'(out_ch),    32'd0);
        check("reset out_last",  32'(out_last),  32'd0);
        check("reset in_ready",  32'(in_ready),  32'd0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d out_ch", i),    32'(out_ch),    32'(vecs[i].exp_ch));
            check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(ch_data(vecs[i].exp_ch)));
            check($sformatf("vec%0d out_last", i),  32'(out_last),  32'd1);
            @(negedge clk);
        end

        // ptr is 2 here; one ch0 beat moves it to 1 before the packet sequence
        mode      = MODE_RR;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pre-packet out_ch", 32'(out_ch), 32'd0);
        @(negedge clk);

        begin
            int beats = 0;
            logic took1;
            for (int k = 0; k < 5; k++) begin
                in_valid = {1'b0, 1'b1, (beats < 3), 1'b0};
                in_last  = {1'b1, 1'b1, (beats == 2), 1'b1};
                #1;
                took1 = in_ready[1];
                @(posedge clk);
                #1;
                check($sformatf("packet beat%0d out_ch", k),   32'(out_ch),   32'(exp_ch_a[k]));
                check($sformatf("packet beat%0d out_last", k), 32'(out_last), 32'(exp_last_a[k]));
                if (took1) beats++;
                @(negedge clk);
            end
        end

        // Load a beat, stall it, then reset asynchronously mid-cycle
        mode      = MODE_SEL;
        sel       = 2'd0;
        in_valid  = 4'b0001;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall load out_ch", 32'(out_ch), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("stall in_ready",  32'(in_ready),  32'd0);
        check("stall out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_data",  32'(out_data),  32'd0);
        check("async rst out_ch",    32'(out_ch),    32'd0);
        check("async rst in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first grant in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("first grant out_valid", 32'(out_valid), 32'd1);
        check("first grant out_data",  32'(out_data),  32'hC0);
        @(negedge clk);

        in_valid3 = 3'b111;
        sel3      = 2'd3;
        #1;
        check("n3 sel3 in_ready", 32'(in_ready3), 32'b000);
        @(negedge clk);
        sel3 = 2'd2;
        #1;
        check("n3 sel2 in_ready", 32'(in_ready3), 32'b100);
        @(posedge clk);
        #1;
        check("n3 sel2 out_data", 32'(out_data3), 32'h33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-channel registered stream multiplexer. It merges NUM_CH valid/ready input streams onto one output stream. The granted channel is chosen either by an external select or by round-robin arbitration. It replaces the fixed 4:1 combinational multiplexer wherever flow control, backpressure or fair sharing of a single downstream consumer is required.

## Interface
- NUM_CH, 4, number of input channels (≥2)
- DATA_W, 8, data width per channel
- SEL_W (localparam), $clog2(NUM_CH), select/channel-index width

- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = MODE_SEL (external select), 1 = MODE_RR (round-robin)
- sel  input  SEL_W  channel select, used in MODE_SEL only
- in_data  input  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- in_valid  input  NUM_CH  per-channel valid
- in_last  input  NUM_CH  per-channel end-of-packet flag
- in_ready  output  NUM_CH  per-channel ready, one-hot or zero
- out_data  output  DATA_W  registered data
- out_ch  output  SEL_W  index of the source channel of out_data
- out_last  output  1  registered in_last of the accepted beat
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream ready

## Operation
- Transfer on an input: in_valid[c] && in_ready[c] at the rising clk. Transfer on the output: out_valid && out_ready.
- Output register accept condition: load = !out_valid || out_ready.
- Grant g, combinational:
  - MODE_SEL: g = sel when in_valid[sel]; otherwise no grant. sel ≥ NUM_CH means no grant.
  - MODE_RR: g is the first c with in_valid[c], searching ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1 (wrap-around).
- in_ready[g] = load && grant_exists && !rst. All other bits are 0.
- On an input transfer, the register captures out_data ← in_data[g], out_ch ← g, out_last ← in_last[g], and sets out_valid ← 1.
- After an input transfer in MODE_RR, ptr ← (g+1) mod NUM_CH. ptr is unchanged in MODE_SEL.
- Output transfer with no input transfer in the same cycle: out_valid ← 0. out_data, out_ch and out_last hold their values.
- Simultaneous output and input transfer: the new beat replaces the old one with no bubble. Full throughput is 1 beat/cycle.
- While out_valid && !out_ready:
  - out_* are held stable.
  - in_ready is all zero.
  - Changes to sel or mode have no effect on the held beat.
- A mode change takes effect at the next grant evaluation. ptr is preserved across mode changes.
- Reset, asynchronous and effective at any time including mid-packet and mid-stall:
  - out_valid=0, out_data=0, out_ch=0, out_last=0.
  - ptr=0, lock cleared.
  - in_ready=0 while rst is high.

## Timing
- Latency: input transfer at edge k makes out_valid=1 with the beat after edge k, i.e. 1 cycle.
- in_ready depends combinationally on in_valid, sel, mode, out_valid and out_ready. There is no combinational path from any input to out_*.
- First grant is possible in the first cycle after rst deasserts.

## Configuration
- Macro STREAM_MUX_LOCK_EN.
- Defined: packet lock.
  - An input transfer with in_last[g]=0 sets lock=1 and lock_ch=g.
  - While lock=1, the grant is forced to lock_ch in both modes, ignoring sel and ptr. If in_valid[lock_ch]=0, there is no grant.
  - An input transfer with in_last=1 clears the lock. In MODE_RR, ptr advances only on that transfer.
- Undefined: every beat is arbitrated independently. in_last is only passed through to out_last. No lock state is present.

## Structure
- Package stream_mux_pkg holds:
  - MODE_SEL/MODE_RR constants.
  - A function for the SEL_W computation.
- One sub-module, rr_arbiter, a combinational rotating-priority search with parameter NUM_CH.
  - Inputs: req[NUM_CH] and ptr.
  - Outputs: gnt_idx and gnt_vld.
- The top module holds the output register, ptr, lock and the handshake logic.

## Test plan
- Reset: assert rst mid-stall with out_valid=1 → out_valid=0, out_data=0, out_ch=0 and in_ready=0 immediately, without waiting for a clock edge.
- MODE_SEL, NUM_CH=4, sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 → in_ready=4'b0100, then next cycle out_data=8'hA5, out_ch=2. Then sel=3 with in_valid[3]=0 → in_ready=0 and out_valid drops after one cycle.
- MODE_RR, in_valid=4'b1111 continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,… at one beat per cycle. With in_valid=4'b1001 → out_ch sequence 0,3,0,3.
- Backpressure: out_ready=0 for 3 cycles with a beat held → out_data, out_ch and out_last stay stable and in_ready=0. Releasing out_ready → the next beat follows with no bubble.
- With STREAM_MUX_LOCK_EN, MODE_RR, ch1 sends a 3-beat packet (in_last on beat 3) while ch2 is valid → out_ch=1,1,1, then 2. Without the macro → out_ch=1,2,1,2,1.
- Out-of-range sel: NUM_CH=3, sel=3 → no grant, in_ready=3'b000.
